bsr_gen: RTL and testbench

- Parametrised boundary-scan register; next generation of the fixed 9-in/5-out BSR.
- Adds bidirectional pad channels (data cell plus output-enable control cell each), instruction-driven mode selection (SAMPLE/EXTEST/INTEST/CLAMP), TLR-synchronous clear and per-cell safe values.
- Sits between the TAP controller/instruction decoder and the pad ring; its TDO feeds the TDO mux.

---
 rtl/bsr_gen_pkg.sv | 34 +++
 rtl/bsr_gen_cell.sv | 59 +++++
 rtl/bsr_gen.sv | 125 ++++++++++++
 tb/tb_bsr_gen.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsr_gen_pkg.sv
// ============================================================================
//  Module   : bsr_gen_pkg
//  Purpose  : Shared types and helpers for the parametrised boundary-scan
//             register: the instruction-driven mode encoding and the chain
//             length / bidir port width calculations.
//  Contents : bsr_mode_t  - SAMPLE / EXTEST / INTEST / CLAMP
//             bsr_len()   - total number of BSR cells
//             bd_width()  - bidir port width (at least 1 so ports stay legal)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bsr_gen_pkg;

    typedef enum logic [1:0] {
        SAMPLE = 2'd0,
        EXTEST = 2'd1,
        INTEST = 2'd2,
        CLAMP  = 2'd3
    } bsr_mode_t;

    // Each bidir pad contributes a data cell and an output-enable cell.
    function automatic int bsr_len(input int num_in, input int num_out, input int num_bidir);
        return num_in + 2 * num_bidir + num_out;
    endfunction

    // With no bidir pads the ports still need a legal width of one bit.
    function automatic int bd_width(input int num_bidir);
        return (num_bidir > 0) ? num_bidir : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bsr_gen_cell.sv
// ============================================================================
//  Module   : bsr_cell
//  Purpose  : One boundary-scan cell: a capture/shift flop clocked on the
//             rising TCK edge and an update flop clocked on the falling edge.
//  Ports    : TCK        - JTAG clock
//             TRST       - asynchronous active-low reset
//             select     - BSR is the selected data register
//             capture    - load parallel input into the capture flop
//             shift      - load serial input into the capture flop
//             update     - transfer capture flop into update flop
//             tlr_reset  - synchronous clear of the update flop
//             pi / si    - parallel and serial inputs
//             cap / upd  - capture and update flop outputs
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsr_cell #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic TCK,
    input  logic TRST,
    input  logic select,
    input  logic capture,
    input  logic shift,
    input  logic update,
    input  logic tlr_reset,
    input  logic pi,
    input  logic si,
    output logic cap,
    output logic upd
);

    // Capture takes priority over shift when both decodes are active.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            cap <= 1'b0;
        end else if (select && capture) begin
            cap <= pi;
        end else if (select && shift) begin
            cap <= si;
        end
    end

    // Falling-edge update keeps pad outputs stable across the rising edge
    // on which the TAP leaves Update-DR; a real update beats the TLR clear.
    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            upd <= RST_VAL;
        end else if (select && update) begin
            upd <= cap;
        end else if (tlr_reset) begin
            upd <= RST_VAL;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bsr_gen.sv
// ============================================================================
//  Module   : bsr_gen
//  Purpose  : Parametrised boundary-scan register between the TAP/instruction
//             decoder and the pad ring. Chain order from TDI to TDO is:
//             input cells, bidir data cells, bidir OE cells, output cells.
//  Ports    : TCK, TRST, TDI, TDO              - JTAG clock/reset/serial data
//             bsr_select, dr_capture, dr_shift,
//             dr_update, tlr_reset             - TAP state decodes
//             bsr_mode                         - SAMPLE/EXTEST/INTEST/CLAMP
//             pin_in  -> sys_in                - input pads to core
//             core_out -> pin_out              - core to output pads
//             core_bd_out/core_bd_oe -> pad_bd_out/pad_bd_oe
//             pad_bd_in -> core_bd_in          - bidir pads
//  Options  : BSR_SAFE_RESET_EN - when defined, TRST and tlr_reset load the
//             update stage with SAFE_VAL instead of all zeros.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsr_gen
    import bsr_gen_pkg::*;
#(
    parameter int NUM_IN    = 9,
    parameter int NUM_OUT   = 5,
    parameter int NUM_BIDIR = 2,
    parameter logic [bsr_len(NUM_IN, NUM_OUT, NUM_BIDIR)-1:0] SAFE_VAL = '0
) (
    input  logic                            TCK,
    input  logic                            TRST,
    input  logic                            TDI,
    output logic                            TDO,
    input  logic                            bsr_select,
    input  logic                            dr_capture,
    input  logic                            dr_shift,
    input  logic                            dr_update,
    input  logic                            tlr_reset,
    input  logic [1:0]                      bsr_mode,
    input  logic [NUM_IN-1:0]               pin_in,
    output logic [NUM_IN-1:0]               sys_in,
    input  logic [NUM_OUT-1:0]              core_out,
    output logic [NUM_OUT-1:0]              pin_out,
    input  logic [bd_width(NUM_BIDIR)-1:0]  core_bd_out,
    input  logic [bd_width(NUM_BIDIR)-1:0]  core_bd_oe,
    output logic [bd_width(NUM_BIDIR)-1:0]  pad_bd_out,
    output logic [bd_width(NUM_BIDIR)-1:0]  pad_bd_oe,
    input  logic [bd_width(NUM_BIDIR)-1:0]  pad_bd_in,
    output logic [bd_width(NUM_BIDIR)-1:0]  core_bd_in
);

    localparam int BSR_LEN  = bsr_len(NUM_IN, NUM_OUT, NUM_BIDIR);
    localparam int BD_BASE  = NUM_IN;
    localparam int CTL_BASE = NUM_IN + NUM_BIDIR;
    localparam int OUT_BASE = NUM_IN + 2 * NUM_BIDIR;

`ifdef BSR_SAFE_RESET_EN
    localparam logic [BSR_LEN-1:0] RST_VEC = SAFE_VAL;
`else
    // Safe values are ignored in this build; masking keeps the parameter
    // referenced so both builds share one parameter list.
    localparam logic [BSR_LEN-1:0] RST_VEC = SAFE_VAL & {BSR_LEN{1'b0}};
`endif

    logic [BSR_LEN-1:0] pi_vec;
    logic [BSR_LEN-1:0] si_vec;
    logic [BSR_LEN-1:0] cap_vec;
    logic [BSR_LEN-1:0] upd_vec;

    bsr_mode_t mode;
    logic      drive_pads;
    logic      drive_core;

    // Cell i shifts from cell i-1; cell 0 takes TDI.
    assign si_vec = {cap_vec[BSR_LEN-2:0], TDI};
    assign TDO    = cap_vec[BSR_LEN-1];

    generate
        for (genvar i = 0; i < BSR_LEN; i++) begin : g_cell
            bsr_cell #(
                .RST_VAL (RST_VEC[i])
            ) u_cell (
                .TCK       (TCK),
                .TRST      (TRST),
                .select    (bsr_select),
                .capture   (dr_capture),
                .shift     (dr_shift),
                .update    (dr_update),
                .tlr_reset (tlr_reset),
                .pi        (pi_vec[i]),
                .si        (si_vec[i]),
                .cap       (cap_vec[i]),
                .upd       (upd_vec[i])
            );
        end
    endgenerate

    // Every mode except SAMPLE drives the pads from the update stage, so
    // INTEST also keeps the pads in a known state; only INTEST feeds the core.
    assign mode       = bsr_mode_t'(bsr_mode);
    assign drive_pads = (mode != SAMPLE);
    assign drive_core = (mode == INTEST);

    assign sys_in  = drive_core ? upd_vec[NUM_IN-1:0]         : pin_in;
    assign pin_out = drive_pads ? upd_vec[OUT_BASE +: NUM_OUT] : core_out;

    generate
        if (NUM_BIDIR > 0) begin : g_bidir
            // Capture sees pad data for the data cells and the core OE for the
            // control cells, matching what each cell later drives.
            assign pi_vec     = {core_out, core_bd_oe, pad_bd_in, pin_in};
            assign pad_bd_out = drive_pads ? upd_vec[BD_BASE  +: NUM_BIDIR] : core_bd_out;
            assign pad_bd_oe  = drive_pads ? upd_vec[CTL_BASE +: NUM_BIDIR] : core_bd_oe;
            assign core_bd_in = drive_core ? upd_vec[BD_BASE  +: NUM_BIDIR] : pad_bd_in;
        end else begin : g_no_bidir
            logic unused_bd;
            assign unused_bd  = ^{core_bd_out, core_bd_oe, pad_bd_in};
            assign pi_vec     = {core_out, pin_in};
            assign pad_bd_out = '0;
            assign pad_bd_oe  = '0;
            assign core_bd_in = '0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_bsr_gen.sv
// ============================================================================
//  Module   : tb_bsr_gen
//  Purpose  : Self-checking bench for bsr_gen with default parameters.
//             Expected values are queued when stimulus is applied and popped
//             when the DUT output is observed.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bsr_gen;
    import bsr_gen_pkg::*;

    logic       TCK;
    logic       TRST;
    logic       TDI;
    logic       TDO;
    logic       bsr_select;
    logic       dr_capture;
    logic       dr_shift;
    logic       dr_update;
    logic       tlr_reset;
    logic [1:0] bsr_mode;
    logic [8:0] pin_in;
    logic [8:0] sys_in;
    logic [4:0] core_out;
    logic [4:0] pin_out;
    logic [1:0] core_bd_out;
    logic [1:0] core_bd_oe;
    logic [1:0] pad_bd_out;
    logic [1:0] pad_bd_oe;
    logic [1:0] pad_bd_in;
    logic [1:0] core_bd_in;

    bsr_gen dut (
        .TCK         (TCK),
        .TRST        (TRST),
        .TDI         (TDI),
        .TDO         (TDO),
        .bsr_select  (bsr_select),
        .dr_capture  (dr_capture),
        .dr_shift    (dr_shift),
        .dr_update   (dr_update),
        .tlr_reset   (tlr_reset),
        .bsr_mode    (bsr_mode),
        .pin_in      (pin_in),
        .sys_in      (sys_in),
        .core_out    (core_out),
        .pin_out     (pin_out),
        .core_bd_out (core_bd_out),
        .core_bd_oe  (core_bd_oe),
        .pad_bd_out  (pad_bd_out),
        .pad_bd_oe   (pad_bd_oe),
        .pad_bd_in   (pad_bd_in),
        .core_bd_in  (core_bd_in)
    );

    initial TCK = 1'b0;
    always #5 TCK = ~TCK;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] expv, input logic [31:0] obs);
        push(tag, expv);
        pop_cmp(obs);
    endtask

    // One full TCK cycle: returns 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge TCK);
        #1;
    endtask

    // Shift an 18-bit value MSB first, then pulse dr_update across one negedge.
    task automatic shift_in(input logic [17:0] val);
        bsr_select = 1'b1;
        dr_shift   = 1'b1;
        for (int k = 17; k >= 0; k--) begin
            TDI = val[k];
            tick();
        end
        dr_shift  = 1'b0;
        TDI       = 1'b0;
        dr_update = 1'b1;
        tick();
        dr_update = 1'b0;
    endtask

    logic [17:0] v;
    logic [17:0] p;
    logic [17:0] r;

    initial begin
        TRST        = 1'b0;
        TDI         = 1'b0;
        bsr_select  = 1'b0;
        dr_capture  = 1'b0;
        dr_shift    = 1'b0;
        dr_update   = 1'b0;
        tlr_reset   = 1'b0;
        bsr_mode    = SAMPLE;
        pin_in      = 9'h1A5;
        core_out    = 5'h13;
        core_bd_out = 2'b01;
        core_bd_oe  = 2'b01;
        pad_bd_in   = 2'b10;
        #2;

        // Reset state in SAMPLE: functional pass-through, chain empty.
        chk("rst_sys_in",     32'h1A5, 32'(sys_in));
        chk("rst_pin_out",    32'h13,  32'(pin_out));
        chk("rst_tdo",        32'h0,   32'(TDO));
        chk("rst_pad_bd_oe",  32'h1,   32'(pad_bd_oe));
        chk("rst_pad_bd_out", 32'h1,   32'(pad_bd_out));
        chk("rst_core_bd_in", 32'h2,   32'(core_bd_in));

        tick();
        tick();
        TRST = 1'b1;
        tick();

        // Capture then shift out all 18 cells MSB first.
        v = {core_out, core_bd_oe, pad_bd_in, pin_in};
        bsr_select = 1'b1;
        dr_capture = 1'b1;
        tick();
        dr_capture = 1'b0;
        dr_shift   = 1'b1;
        TDI        = 1'b0;
        for (int k = 17; k >= 0; k--) push("shift_tdo", 32'(v[k]));
        for (int k = 0; k < 18; k++) begin
            pop_cmp(32'(TDO));
            tick();
        end
        dr_shift = 1'b0;
        chk("shift_tail_zero", 32'h0, 32'(TDO));

        // PRELOAD then EXTEST.
        p = 18'h2AB3C;
        shift_in(p);
        chk("preload_sample_pin_out", 32'(core_out), 32'(pin_out));
        bsr_mode = EXTEST;
        #1;
        chk("extest_pin_out",    32'(p[17:13]), 32'(pin_out));
        chk("extest_pad_bd_oe",  32'(p[12:11]), 32'(pad_bd_oe));
        chk("extest_pad_bd_out", 32'(p[10:9]),  32'(pad_bd_out));
        chk("extest_sys_in",     32'(pin_in),   32'(sys_in));
        chk("extest_core_bd_in", 32'(pad_bd_in), 32'(core_bd_in));

        // Update lands on the negedge, not when dr_update rises.
        dr_capture = 1'b1;
        tick();
        dr_capture = 1'b0;
        dr_update  = 1'b1;
        #1;
        chk("upd_before_negedge", 32'(p[17:13]), 32'(pin_out));
        @(negedge TCK);
        #1;
        chk("upd_after_negedge",    32'(v[17:13]), 32'(pin_out));
        chk("upd_after_negedge_oe", 32'(v[12:11]), 32'(pad_bd_oe));
        tick();
        dr_update = 1'b0;

        // INTEST: core inputs from the update stage, pads also held.
        r = {5'h1A, 2'b10, 2'b11, 9'h0F0};
        shift_in(r);
        bsr_mode = INTEST;
        #1;
        chk("intest_sys_in",     32'h0F0, 32'(sys_in));
        chk("intest_core_bd_in", 32'h3,   32'(core_bd_in));
        chk("intest_pin_out",    32'h1A,  32'(pin_out));
        chk("intest_pad_bd_oe",  32'h2,   32'(pad_bd_oe));
        pin_in = 9'h05A;
        #1;
        chk("intest_sys_in_hold", 32'h0F0, 32'(sys_in));
        bsr_mode = SAMPLE;
        #1;
        chk("sample_sys_in_comb", 32'h05A, 32'(sys_in));

        // Capture beats shift: hold would show r[17]=1, shift r[16]=1.
        bsr_mode   = EXTEST;
        core_out   = 5'h03;
        dr_capture = 1'b1;
        dr_shift   = 1'b1;
        tick();
        dr_capture = 1'b0;
        dr_shift   = 1'b0;
        chk("prio_capture_over_shift", 32'(core_out[4]), 32'(TDO));

        // Update ignored while the BSR is not selected.
        bsr_select = 1'b0;
        dr_update  = 1'b1;
        tick();
        tick();
        dr_update = 1'b0;
        chk("unselected_update_pin_out", 32'h1A, 32'(pin_out));

        // CLAMP: pads stay on the held update value.
        bsr_mode = CLAMP;
        core_out = 5'h1F;
        tick();
        chk("clamp_pin_out",   32'h1A,         32'(pin_out));
        chk("clamp_pad_bd_oe", 32'h2,          32'(pad_bd_oe));
        chk("clamp_sys_in",    32'(pin_in),    32'(sys_in));

        // TLR synchronous clear.
        bsr_mode  = EXTEST;
        tlr_reset = 1'b1;
        tick();
        tlr_reset = 1'b0;
        chk("tlr_pin_out",    32'h0, 32'(pin_out));
        chk("tlr_pad_bd_oe",  32'h0, 32'(pad_bd_oe));
        chk("tlr_pad_bd_out", 32'h0, 32'(pad_bd_out));

        // TRST mid-shift clears the chain immediately.
        core_out   = 5'h13;
        pin_in     = 9'h1A5;
        v          = {core_out, core_bd_oe, pad_bd_in, pin_in};
        bsr_select = 1'b1;
        dr_capture = 1'b1;
        tick();
        dr_capture = 1'b0;
        dr_shift   = 1'b1;
        tick();
        tick();
        tick();
        chk("midshift_tdo", 32'(v[14]), 32'(TDO));
        TRST       = 1'b0;
        dr_shift   = 1'b0;
        bsr_select = 1'b0;
        #1;
        chk("trst_tdo_immediate", 32'h0, 32'(TDO));
        chk("trst_pin_out",       32'h0, 32'(pin_out));
        tick();
        TRST = 1'b1;
        tick();
        bsr_select = 1'b1;
        dr_capture = 1'b1;
        tick();
        dr_capture = 1'b0;
        bsr_select = 1'b0;
        chk("post_trst_capture_tdo", 32'(v[17]), 32'(TDO));

        n_cmp++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
